// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets and FSM encoding shared by the interrupt controller and its bench
package irq_ctrl_pkg;
    localparam logic [1:0] REG_PEND   = 2'd0;
    localparam logic [1:0] REG_ENA    = 2'd1;
    localparam logic [1:0] REG_ACTIVE = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2,
        S_GAP  = 2'd3
    } state_t;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: per-bit 2-flop synchroniser with a registered rising-edge pulse
module irq_sync #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] src,
    output logic [N-1:0] rise
);
    logic [N-1:0] s1, s2, s3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            s3   <= '0;
            rise <= '0;
        end else begin
            s1   <= src;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority edge-triggered interrupt controller for the CPU irq/intack/rti handshake
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 16,
    parameter int IDX_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] src,
    input  logic               sel,
    input  logic               wr,
    input  logic [1:0]         rsel,
    input  logic [31:0]        din,
    output logic [31:0]        dout,
    output logic               irq,
    input  logic               intack,
    input  logic               rti,
    input  logic               abort
);
    logic [NUM_IRQ-1:0] pend, ena, rise, live, clr, set;
    logic [IDX_W-1:0]   act_idx, win;
    logic               gen, act_valid, req, wr_en;
    state_t             state;

    function automatic logic [IDX_W-1:0] prio(input logic [NUM_IRQ-1:0] v);
        prio = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (v[i]) prio = IDX_W'(i);
    endfunction

    irq_sync #(.N(NUM_IRQ)) u_sync (.clk(clk), .rst(rst), .src(src), .rise(rise));

    // Set terms are ORed in after clears so a same-cycle edge or trigger is never lost.
    always_comb begin
        wr_en = sel & wr;
        live  = pend & ena;
        req   = gen & |live;
        win   = prio(live);
        clr   = ((wr_en && rsel == REG_PEND) ? din[NUM_IRQ-1:0] : '0) |
                ((state == S_REQ && intack && req) ? NUM_IRQ'(1) << win : '0);
        set   = rise | ((wr_en && rsel == REG_CTRL) ? NUM_IRQ'(din[31:16]) : '0);
        dout  = rsel == REG_PEND ? 32'(pend) :
                rsel == REG_ENA  ? 32'(ena)  :
                rsel == REG_ACTIVE ? {act_valid, {(31-IDX_W){1'b0}}, act_idx} : {31'b0, gen};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            ena       <= '0;
            gen       <= 1'b0;
            act_valid <= 1'b0;
            act_idx   <= '0;
            irq       <= 1'b0;
            state     <= S_IDLE;
        end else begin
            pend <= (pend & ~clr) | set;
            if (wr_en && rsel == REG_ENA) ena <= din[NUM_IRQ-1:0];
            if (wr_en && rsel == REG_CTRL) gen <= din[0];
            case (state)
                S_IDLE, S_GAP: begin
                    if (intack) begin
                        state     <= S_SVC;
                        act_valid <= 1'b0;
                        act_idx   <= '0;
                    end else if (state == S_IDLE && req) begin
                        state <= S_REQ;
                        irq   <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (intack) begin
                        state     <= S_SVC;
                        irq       <= 1'b0;
                        act_valid <= req;
                        act_idx   <= req ? win : '0;
                    end else if (!req) begin
                        state <= S_IDLE;
                        irq   <= 1'b0;
                    end
                end
                S_SVC: begin
                    if (!intack && (rti || abort)) begin
                        state     <= S_GAP;
                        act_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, wr = 1'b0;
    logic        intack = 1'b0, rti = 1'b0, abort = 1'b0;
    logic [15:0] src = '0;
    logic [1:0]  rsel = '0;
    logic [31:0] din = '0, dout;
    logic        irq;
    typedef struct {string tag; logic [31:0] v;} exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(16), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .src(src), .sel(sel), .wr(wr), .rsel(rsel), .din(din),
        .dout(dout), .irq(irq), .intack(intack), .rti(rti), .abort(abort)
    );

    task automatic tick(int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic expv(string t, logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic obs(logic [31:0] o);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required none", o);
        end else begin
            e = sb.pop_front();
            assert (o === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic chk(string t, logic [31:0] o, logic [31:0] v);
        expv(t, v);
        obs(o);
    endtask

    task automatic chk_rd(string t, logic [1:0] r, logic [31:0] v);
        expv(t, v);
        rsel = r;
        #1;
        obs(dout);
    endtask

    task automatic wr_reg(logic [1:0] r, logic [31:0] d);
        sel = 1'b1; wr = 1'b1; rsel = r; din = d;
        tick();
        sel = 1'b0; wr = 1'b0; din = '0;
    endtask

    task automatic pulse_ack();
        intack = 1'b1; tick(); intack = 1'b0;
    endtask

    task automatic pulse_rti();
        rti = 1'b1; tick(); rti = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        chk("rst_irq", 32'(irq), 0);
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));
        chk_rd("rst_pend", REG_PEND, 0);
        chk_rd("rst_ena", REG_ENA, 0);
        chk_rd("rst_active", REG_ACTIVE, 0);
        chk_rd("rst_ctrl", REG_CTRL, 0);
        // 1: single source latency and acknowledge
        wr_reg(REG_ENA, 32'h0004);
        wr_reg(REG_CTRL, 32'h1);
        src = 16'h0004;
        expv("t1_pend_t2", 0); expv("t1_irq_t2", 0);
        expv("t1_pend_t3", 4); expv("t1_irq_t3", 0);
        expv("t1_irq_t4", 1);
        tick(3);
        rsel = REG_PEND; #1; obs(dout); obs(32'(irq));
        tick(); rsel = REG_PEND; #1; obs(dout); obs(32'(irq));
        tick(); obs(32'(irq));
        chk("t1_state_req", 32'(dut.state), 32'(S_REQ));
        src = '0;
        pulse_ack();
        chk("t1_irq_ack", 32'(irq), 0);
        chk_rd("t1_active", REG_ACTIVE, 32'h80000002);
        chk_rd("t1_pend_ack", REG_PEND, 0);
        pulse_rti();
        chk("t1_state_gap", 32'(dut.state), 32'(S_GAP));
        chk_rd("t1_active_gap", REG_ACTIVE, 32'h00000002);
        tick();
        chk("t1_state_idle", 32'(dut.state), 32'(S_IDLE));
        // 2: priority between two pending sources, GAP before re-raise
        wr_reg(REG_ENA, 32'hFFFF);
        wr_reg(REG_CTRL, 32'h0220_0001);
        tick();
        chk("t2_irq", 32'(irq), 1);
        pulse_ack();
        chk_rd("t2_active5", REG_ACTIVE, 32'h80000005);
        chk_rd("t2_pend", REG_PEND, 32'h200);
        pulse_rti();
        chk("t2_irq_gap", 32'(irq), 0);
        tick();
        chk("t2_irq_idle", 32'(irq), 0);
        tick();
        chk("t2_irq_re", 32'(irq), 1);
        pulse_ack();
        chk_rd("t2_active9", REG_ACTIVE, 32'h80000009);
        chk_rd("t2_pend0", REG_PEND, 0);
        pulse_rti();
        tick();
        // 3: request withdrawn before ack, then spurious ack
        wr_reg(REG_CTRL, 32'h0001_0001);
        tick();
        chk("t3_irq", 32'(irq), 1);
        wr_reg(REG_PEND, 32'h1);
        tick();
        chk("t3_irq_drop", 32'(irq), 0);
        chk("t3_state_idle", 32'(dut.state), 32'(S_IDLE));
        pulse_ack();
        chk("t3_state_svc", 32'(dut.state), 32'(S_SVC));
        chk_rd("t3_active_spur", REG_ACTIVE, 0);
        pulse_rti();
        tick();
        // 4: edge beats same-cycle W1C; edge during SVC waits for rti+GAP
        src = 16'h0008;
        tick(3);
        wr_reg(REG_PEND, 32'h8);
        src = '0;
        chk_rd("t4_pend_set_wins", REG_PEND, 32'h8);
        tick();
        chk("t4_irq", 32'(irq), 1);
        pulse_ack();
        chk_rd("t4_active3", REG_ACTIVE, 32'h80000003);
        src = 16'h0010;
        tick(5);
        chk("t4_irq_svc", 32'(irq), 0);
        chk_rd("t4_pend_svc", REG_PEND, 32'h10);
        chk("t4_state_svc", 32'(dut.state), 32'(S_SVC));
        pulse_rti();
        chk("t4_irq_gap", 32'(irq), 0);
        tick();
        chk("t4_irq_idle", 32'(irq), 0);
        tick();
        chk("t4_irq_re", 32'(irq), 1);
        pulse_ack();
        chk_rd("t4_active4", REG_ACTIVE, 32'h80000004);
        src = '0;
        pulse_rti();
        tick();
        // 5: software trigger and abort
        wr_reg(REG_CTRL, 32'h0001_0001);
        chk_rd("t5_ctrl", REG_CTRL, 1);
        tick();
        chk("t5_irq", 32'(irq), 1);
        pulse_ack();
        chk_rd("t5_active0", REG_ACTIVE, 32'h80000000);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_state_gap", 32'(dut.state), 32'(S_GAP));
        chk_rd("t5_active_inv", REG_ACTIVE, 0);
        tick(2);
        chk("t5_irq_none", 32'(irq), 0);
        wr_reg(REG_CTRL, 32'h0003_0001);
        tick();
        pulse_ack();
        chk_rd("t5_active0b", REG_ACTIVE, 32'h80000000);
        abort = 1'b1; tick(); abort = 1'b0;
        tick(2);
        chk("t5_irq_remain", 32'(irq), 1);
        pulse_ack();
        chk_rd("t5_active1", REG_ACTIVE, 32'h80000001);
        pulse_rti();
        tick();
        // 6: asynchronous reset during service
        wr_reg(REG_ENA, 32'h1);
        wr_reg(REG_CTRL, 32'h0031_0001);
        tick();
        pulse_ack();
        chk_rd("t6_pend", REG_PEND, 32'h30);
        chk("t6_state_svc", 32'(dut.state), 32'(S_SVC));
        #1 rst = 1'b1;
        #1;
        chk("t6_state_rst", 32'(dut.state), 32'(S_IDLE));
        chk("t6_irq_rst", 32'(irq), 0);
        chk_rd("t6_pend_rst", REG_PEND, 0);
        chk_rd("t6_ena_rst", REG_ENA, 0);
        chk_rd("t6_active_rst", REG_ACTIVE, 0);
        chk_rd("t6_ctrl_rst", REG_CTRL, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_irq_after", 32'(irq), 0);
        chk("t6_state_after", 32'(dut.state), 32'(S_IDLE));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
